// File: rtl/slc3_mem_sequencer_if.sv
// slc3_mem_sequencer_if: CPU req/ready transaction bus plus the asynchronous SRAM strobe/data bus.
// The sequencer takes the slave side; the CPU and board model drive the master side.
interface slc3_mem_sequencer_if #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int SRAM_ADDR_W = 20
);
   logic                   req;
   logic                   we;
   logic [ADDR_W-1:0]      addr;
   logic [DATA_W-1:0]      wdata;
   logic                   ready;
   logic [DATA_W-1:0]      rdata;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic                   sram_ce_n;
   logic                   sram_oe_n;
   logic                   sram_we_n;
   logic                   sram_ub_n;
   logic                   sram_lb_n;
   logic [DATA_W-1:0]      sram_dq_out;
   logic                   sram_dq_oe;
   logic [DATA_W-1:0]      sram_dq_in;
   modport master (
      output req, we, addr, wdata, sram_dq_in,
      input  ready, rdata, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
             sram_ub_n, sram_lb_n, sram_dq_out, sram_dq_oe
   );
   modport slave (
      input  req, we, addr, wdata, sram_dq_in,
      output ready, rdata, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
             sram_ub_n, sram_lb_n, sram_dq_out, sram_dq_oe
   );
endinterface

// File: rtl/slc3_mem_sequencer.sv
// slc3_mem_sequencer: single-transaction async SRAM strobe sequencer with wait states and a local I/O decode.
// Reads of IO_ADDR return the switches, writes load the hex register; both complete in one cycle.
module slc3_mem_sequencer #(
   parameter int              ADDR_W      = 16,
   parameter int              DATA_W      = 16,
   parameter int              SRAM_ADDR_W = 20,
   parameter int              WAIT_STATES = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR   = 16'hFFFF,
   parameter int              HEX_DIGITS  = 4
) (
   input  logic                    Clk_i,
   input  logic                    Reset_i,
   input  logic [DATA_W-1:0]       Switches_i,
   output logic [4*HEX_DIGITS-1:0] hex_out_o,
   slc3_mem_sequencer_if.slave     bus
);
   typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, DONE} state_e;
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [SRAM_ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic [4*HEX_DIGITS-1:0] hex_q, hex_d;
   logic                    io_hit;
   logic                    last;
   logic                    active;
   assign io_hit = bus.addr == IO_ADDR;
   assign last   = cnt_q == WS;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      hex_d   = hex_q;
      case (state_q)
         IDLE: if (bus.req) begin
            addr_d  = SRAM_ADDR_W'(bus.addr);
            wdata_d = bus.wdata;
            cnt_d   = '0;
            state_d = io_hit ? DONE : (bus.we ? WR : RD);
            hex_d   = (io_hit && bus.we) ? bus.wdata[4*HEX_DIGITS-1:0] : hex_q;
            rdata_d = (io_hit && !bus.we) ? Switches_i : rdata_q;
         end
         RD: begin
            cnt_d   = last ? cnt_q : cnt_q + 4'd1;
            rdata_d = last ? bus.sram_dq_in : rdata_q;
            state_d = last ? DONE : RD;
         end
         WR: begin
            cnt_d   = last ? cnt_q : cnt_q + 4'd1;
            state_d = last ? WR_HOLD : WR;
         end
         WR_HOLD: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         hex_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hex_q   <= hex_d;
      end
   end
   // Strobes are decoded from state only; WR_HOLD keeps the chip and data driven while we_n rises.
   assign active          = state_q inside {RD, WR, WR_HOLD};
   assign bus.ready       = state_q == DONE;
   assign bus.rdata       = rdata_q;
   assign bus.sram_addr   = addr_q;
   assign bus.sram_ce_n   = !active;
   assign bus.sram_ub_n   = !active;
   assign bus.sram_lb_n   = !active;
   assign bus.sram_oe_n   = state_q != RD;
   assign bus.sram_we_n   = state_q != WR;
   assign bus.sram_dq_oe  = state_q inside {WR, WR_HOLD};
   assign bus.sram_dq_out = wdata_q;
   assign hex_out_o       = hex_q;
endmodule

// File: tb/tb_slc3_mem_sequencer.sv
// tb_slc3_mem_sequencer: directed transactions checked every cycle against a per-cycle phase timeline model,
// plus literal latency, data and strobe-count expectations.
module tb_slc3_mem_sequencer;
   localparam int W = 2;
   typedef struct packed {logic ce_n, oe_n, we_n, dq_oe, ready, cap;} rec_t;
   localparam rec_t IDLE_R = 6'b111000;
   localparam rec_t RD_R   = 6'b001000;
   localparam rec_t RDL_R  = 6'b001001;
   localparam rec_t WR_R   = 6'b010100;
   localparam rec_t HOLD_R = 6'b011100;
   localparam rec_t DONE_R = 6'b111010;
   logic        clk = 0;
   logic        rst = 1;
   logic [15:0] sw = 16'h0000;
   logic [15:0] hex;
   int          tests = 0, errors = 0;
   int          ce_cnt = 0, oe_cnt = 0, we_cnt = 0, dqoe_cnt = 0, rdy_cnt = 0;
   int          lat, n, c0, o0, r0;
   bit          started = 0;
   rec_t        q[$];
   logic [15:0] m_rdata = 0, m_hex = 0, m_wdata = 0;
   logic [19:0] m_addr = 0;
   logic [15:0] addrs[3];
   logic [15:0] exps[3];
   slc3_mem_sequencer_if #(.ADDR_W(16), .DATA_W(16), .SRAM_ADDR_W(20)) bus();
   slc3_mem_sequencer #(.WAIT_STATES(W)) dut (
      .Clk_i(clk), .Reset_i(rst), .Switches_i(sw), .hex_out_o(hex), .bus(bus)
   );
   always #5 clk = ~clk;
   // SRAM contents: each word is its address xor a fixed pattern, so 0x0010 holds 0xBEEF.
   assign bus.sram_dq_in = bus.sram_addr[15:0] ^ 16'hBEFF;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(posedge clk) begin
      rec_t r;
      started = 1;
      if (rst) begin
         q.delete();
         m_rdata = 0;
         m_hex   = 0;
         m_addr  = 0;
         m_wdata = 0;
      end else if (q.size() != 0) begin
         r = q.pop_front();
         if (r.cap) m_rdata = m_addr[15:0] ^ 16'hBEFF;
      end else if (bus.req) begin
         m_addr  = {4'h0, bus.addr};
         m_wdata = bus.wdata;
         if (bus.addr == 16'hFFFF) begin
            if (bus.we) m_hex = bus.wdata;
            else m_rdata = sw;
         end else begin
            for (int i = 0; i <= W; i++) q.push_back(bus.we ? WR_R : (i == W ? RDL_R : RD_R));
            if (bus.we) q.push_back(HOLD_R);
         end
         q.push_back(DONE_R);
      end
   end
   always @(negedge clk) begin
      rec_t e;
      if (started) begin
         e = (q.size() != 0) ? q[0] : IDLE_R;
         check("ce_n", bus.sram_ce_n, e.ce_n);
         check("ub_n", bus.sram_ub_n, e.ce_n);
         check("lb_n", bus.sram_lb_n, e.ce_n);
         check("oe_n", bus.sram_oe_n, e.oe_n);
         check("we_n", bus.sram_we_n, e.we_n);
         check("dq_oe", bus.sram_dq_oe, e.dq_oe);
         check("ready", bus.ready, e.ready);
         check("rdata", bus.rdata, m_rdata);
         check("hex_out", hex, m_hex);
         check("sram_addr", bus.sram_addr, m_addr);
         check("oe_excl", bus.sram_dq_oe & ~bus.sram_oe_n, 0);
         if (e.dq_oe) check("dq_out", bus.sram_dq_out, m_wdata);
         if (!bus.sram_ce_n) ce_cnt++;
         if (!bus.sram_oe_n) oe_cnt++;
         if (!bus.sram_we_n) we_cnt++;
         if (bus.sram_dq_oe) dqoe_cnt++;
         if (bus.ready) rdy_cnt++;
      end
   end
   task automatic run(input logic w, input logic [15:0] a, input logic [15:0] d, output int l);
      @(negedge clk);
      bus.req = 1; bus.we = w; bus.addr = a; bus.wdata = d;
      @(posedge clk);
      @(negedge clk);
      bus.req = 0; bus.we = ~w; bus.addr = 16'h0BAD; bus.wdata = 16'hDEAD;
      l = 1;
      while (!bus.ready && l < 40) begin
         @(negedge clk);
         l++;
      end
   endtask
   initial begin
      bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (5) @(negedge clk);
      check("rst_ce_n", bus.sram_ce_n, 1);
      check("rst_oe_n", bus.sram_oe_n, 1);
      check("rst_we_n", bus.sram_we_n, 1);
      check("rst_ub_lb", {bus.sram_ub_n, bus.sram_lb_n}, 2'b11);
      check("rst_ready", bus.ready, 0);
      check("rst_rdata", bus.rdata, 16'h0000);
      check("rst_hex", hex, 16'h0000);
      check("rst_dq_oe", bus.sram_dq_oe, 0);
      check("rst_dq_out", bus.sram_dq_out, 16'h0000);
      check("rst_saddr", bus.sram_addr, 20'h00000);
      @(posedge clk); c0 = ce_cnt; o0 = oe_cnt;
      run(0, 16'h0010, 16'h0000, lat);
      check("rd_lat", lat, 4);
      check("rd_data", bus.rdata, 16'hBEEF);
      check("rd_saddr", bus.sram_addr, 20'h00010);
      @(posedge clk);
      check("rd_ce_cycles", ce_cnt - c0, 3);
      check("rd_oe_cycles", oe_cnt - o0, 3);
      c0 = we_cnt; o0 = dqoe_cnt;
      run(1, 16'h0020, 16'h1234, lat);
      check("wr_lat", lat, 5);
      check("wr_rdata_kept", bus.rdata, 16'hBEEF);
      check("wr_dq_out", bus.sram_dq_out, 16'h1234);
      @(posedge clk);
      check("wr_we_cycles", we_cnt - c0, 3);
      check("wr_dqoe_cycles", dqoe_cnt - o0, 4);
      sw = 16'h00A5;
      c0 = ce_cnt;
      run(1, 16'hFFFF, 16'hCAFE, lat);
      check("io_wr_lat", lat, 1);
      check("io_hex", hex, 16'hCAFE);
      run(0, 16'hFFFF, 16'h0000, lat);
      check("io_rd_lat", lat, 1);
      check("io_rdata", bus.rdata, 16'h00A5);
      @(posedge clk);
      check("io_no_ce", ce_cnt - c0, 0);
      addrs = '{16'h0100, 16'h0200, 16'h0300};
      exps  = '{16'hBFFF, 16'hBCFF, 16'hBDFF};
      r0 = rdy_cnt;
      @(negedge clk);
      bus.req = 1; bus.we = 0; bus.addr = addrs[0];
      for (int i = 0; i < 3; i++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (n == 2) bus.addr = 16'h7777;
         end while (!bus.ready && n < 40);
         check("b2b_rdata", bus.rdata, exps[i]);
         if (i > 0) check("b2b_gap", n, 5);
         if (i < 2) bus.addr = addrs[i+1];
      end
      bus.req = 0;
      @(posedge clk);
      check("b2b_pulses", rdy_cnt - r0, 3);
      check("b2b_saddr", bus.sram_addr, 20'h00300);
      r0 = rdy_cnt;
      @(negedge clk);
      bus.req = 1; bus.we = 1; bus.addr = 16'h0040; bus.wdata = 16'h5555;
      @(negedge clk);
      bus.req = 0;
      check("abort_in_wr", bus.sram_we_n, 0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_we_n", bus.sram_we_n, 1);
      check("abort_ce_n", bus.sram_ce_n, 1);
      check("abort_dq_oe", bus.sram_dq_oe, 0);
      check("abort_rdata", bus.rdata, 16'h0000);
      repeat (3) @(negedge clk);
      @(posedge clk);
      check("abort_no_ready", rdy_cnt - r0, 0);
      run(0, 16'h0010, 16'h0000, lat);
      check("post_rd_lat", lat, 4);
      check("post_rd_data", bus.rdata, 16'hBEEF);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/slc3_mem_sequencer.md
Name: slc3_mem_sequencer

Overview:
- Parametrised memory/IO access sequencer for the SLC-3 datapath. It replaces the fixed-timing memory states and the Mem2IO decode.
- The CPU issues single transactions through a req/ready handshake. The block runs the asynchronous SRAM strobe sequence with a configurable number of wait states.
- A configurable I/O address is decoded locally: reads return the switches, writes load the hex-display register.
- Sits between the datapath (MAR/MDR) and the board SRAM tristate buffer.

Parameters:
- ADDR_W, 16, CPU address width.
- DATA_W, 16, data width.
- SRAM_ADDR_W, 20, external SRAM address width; must be >= ADDR_W.
- WAIT_STATES, 2, extra strobe cycles per SRAM access; 0..15 legal.
- IO_ADDR, 16'hFFFF, address decoded as I/O instead of SRAM.
- HEX_DIGITS, 4, nibbles in the hex register; 4*HEX_DIGITS must be <= DATA_W.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  1  transaction request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  transaction address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- ready  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result; valid while ready = 1; held until the next read completes.
- Switches  in  DATA_W  board switches, returned on an IO_ADDR read.
- hex_out  out  4*HEX_DIGITS  hex-display register.
- sram_addr  out  SRAM_ADDR_W  zero-extended latched address.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.
- sram_dq_out  out  DATA_W  write data to the tristate buffer.
- sram_dq_oe  out  1  tristate drive enable.
- sram_dq_in  in  DATA_W  data read from the tristate buffer.

Behaviour:
- Reset values: state IDLE, ready 0, rdata 0, hex_out 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, all five strobes 1.
- Reset mid-transaction aborts at that edge. No ready is produced, and the strobes are inactive from the following cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from req/addr to any output.
- States: IDLE, RD, WR, WR_HOLD, DONE. A wait counter counts 0..WAIT_STATES.
- IDLE, req = 1 at edge k: latch addr, we, wdata, and drive sram_addr = {0, addr}.
  - addr == IO_ADDR, read: rdata <= Switches at edge k; next state DONE.
  - addr == IO_ADDR, write: hex_out <= wdata[4*HEX_DIGITS-1:0] at edge k; next state DONE. I/O latency is 1 cycle and no SRAM strobe is asserted.
  - Otherwise: next state is RD or WR according to we; counter cleared.
- RD: ce_n = oe_n = ub_n = lb_n = 0. Held for WAIT_STATES+1 cycles. On the last RD edge, rdata <= sram_dq_in, then DONE. Read latency is WAIT_STATES+2 cycles from edge k to ready.
- WR: ce_n = we_n = ub_n = lb_n = 0, oe_n = 1, sram_dq_oe = 1, sram_dq_out = latched wdata. Held for WAIT_STATES+1 cycles, then WR_HOLD.
- WR_HOLD: we_n = 1; ce_n, dq_oe and dq_out unchanged for 1 cycle (data hold time), then DONE. Write latency is WAIT_STATES+3 cycles.
- DONE: ready = 1 for exactly one cycle, strobes inactive, dq_oe 0; next state IDLE. req is ignored in DONE.
- If req is held high, a new transaction is accepted on the IDLE edge after DONE, so back-to-back accesses have a 1-cycle IDLE bubble.
- Changes to addr/we/wdata during a transaction have no effect.
- sram_dq_oe and sram_oe_n are never both active in the same cycle.
- WAIT_STATES = 0 gives a 1-cycle RD and a 1-cycle WR.

Test Plan:
- Reset, then idle 5 cycles -> strobes all 1, ready 0, rdata 0, hex_out 0, dq_oe 0.
- WAIT_STATES=2; read addr 16'h0010 with sram_dq_in = 16'hBEEF -> ce_n/oe_n low for exactly 3 cycles, ready high 4 cycles after acceptance, rdata = 16'hBEEF, sram_addr = 20'h00010.
- Write 16'h1234 to 16'h0020 -> we_n low 3 cycles with dq_oe = 1 and dq_out = 16'h1234; WR_HOLD cycle has we_n = 1 and dq_oe = 1; ready at cycle 5; rdata unchanged.
- Write 16'hCAFE to 16'hFFFF, then read 16'hFFFF with Switches = 16'h00A5 -> hex_out = 16'hCAFE, rdata = 16'h00A5, each ready 1 cycle after acceptance, ce_n never asserted.
- req held high for three reads, with addr changed mid-transaction -> three ready pulses separated by IDLE bubbles; each rdata corresponds to the address latched at acceptance.
- Reset asserted in cycle 2 of a write -> no ready pulse; we_n, ce_n and dq_oe inactive the cycle after reset; the next read completes normally.
